// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I decode definitions.
//   - 7-bit major opcode constants
//   - op_e : operation class presented to the execute stage on o_op
//   - fmt_e: immediate / operand format of an instruction
//   - sext12(): sign-extend a 12-bit immediate field to 32 bits
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_LUI    = 4'd1,
        OP_AUIPC  = 4'd2,
        OP_JAL    = 4'd3,
        OP_JALR   = 4'd4,
        OP_BRANCH = 4'd5,
        OP_LOAD   = 4'd6,
        OP_STORE  = 4'd7,
        OP_IMM    = 4'd8,
        OP_ALU    = 4'd9,
        OP_SYSTEM = 4'd10,
        OP_FENCE  = 4'd11
    } op_e;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/cpu_decode_imm.sv
// cpu_decode_imm: combinational RV32I classifier and immediate generator.
// Ports:
//   instruction  in   32  instruction word being decoded
//   op           out  4   operation class (OP_NOP when illegal)
//   imm          out  32  immediate for the instruction's format
//   uses_rs1     out  1   instruction reads rs1
//   uses_rs2     out  1   instruction reads rs2
//   writes_rd    out  1   instruction writes rd
//   illegal      out  1   unrecognised opcode / funct combination
module cpu_decode_imm
    import cpu_pkg::*;
(
    input  logic [31:0] instruction,
    output op_e         op,
    output logic [31:0] imm,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       legal;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    always_comb begin
        fmt       = FMT_NONE;
        op        = OP_NOP;
        writes_rd = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OPC_LUI:    begin fmt = FMT_U; op = OP_LUI;   writes_rd = 1'b1; end
            OPC_AUIPC:  begin fmt = FMT_U; op = OP_AUIPC; writes_rd = 1'b1; end
            OPC_JAL:    begin fmt = FMT_J; op = OP_JAL;   writes_rd = 1'b1; end
            OPC_JALR: begin
                fmt = FMT_I; op = OP_JALR; writes_rd = 1'b1;
                legal = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                fmt = FMT_B; op = OP_BRANCH;
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                fmt = FMT_I; op = OP_LOAD; writes_rd = 1'b1;
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                fmt = FMT_S; op = OP_STORE;
                legal = !funct3[2] && (funct3[1:0] != 2'b11);
            end
            OPC_OP_IMM: begin
                fmt = FMT_I; op = OP_IMM; writes_rd = 1'b1;
                // Shift-immediates carry a funct7 in the upper immediate bits.
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            OPC_OP: begin
                fmt = FMT_R; op = OP_ALU; writes_rd = 1'b1;
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_SYSTEM: begin fmt = FMT_I; op = OP_SYSTEM; writes_rd = 1'b1; end
            OPC_FENCE:  begin fmt = FMT_I; op = OP_FENCE; end
            default:    legal = 1'b0;
        endcase
        if (!legal) begin
            fmt       = FMT_NONE;
            op        = OP_NOP;
            writes_rd = 1'b0;
        end
    end

    assign illegal  = !legal;
    assign uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

    always_comb begin
        case (fmt)
            FMT_I:   imm = sext12(instruction[31:20]);
            FMT_S:   imm = sext12({instruction[31:25], instruction[11:7]});
            FMT_B:   imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            FMT_U:   imm = {instruction[31:12], 12'b0};
            FMT_J:   imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: RV32I decode stage between fetch and execute.
// Accepts a tagged instruction from fetch, reads two regfile ports, checks a
// pending-write scoreboard and issues registered decoded operands.
// Ports:
//   i_clock, i_reset             clock / synchronous active-high reset
//   i_stall                      execute cannot accept an issue this cycle
//   o_busy                       back-pressure to fetch (unconsumed input held)
//   i_tag, i_instruction, i_pc   instruction from fetch; new tag = new instruction
//   o_rs1_addr, o_rs2_addr       regfile read addresses (combinational)
//   i_rs1_data, i_rs2_data       regfile read data
//   i_wb_valid, i_wb_rd          writeback completion, clears scoreboard bit
//   o_tag .. o_illegal           registered decoded outputs to execute
//
// state          | meaning
// S_IDLE         | waiting for a new tag, or issuing it
// S_WAIT_HAZARD  | new instruction held, a source register is still pending
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int          TAG_WIDTH = 8,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_stall,
    output logic                 o_busy,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [31:0]          i_instruction,
    input  logic [31:0]          i_pc,
    output logic [4:0]           o_rs1_addr,
    output logic [4:0]           o_rs2_addr,
    input  logic [31:0]          i_rs1_data,
    input  logic [31:0]          i_rs2_data,
    input  logic                 i_wb_valid,
    input  logic [4:0]           i_wb_rd,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [31:0]          o_pc,
    output logic [31:0]          o_instruction,
    output logic [3:0]           o_op,
    output logic [4:0]           o_rd,
    output logic [31:0]          o_rs1,
    output logic [31:0]          o_rs2,
    output logic [31:0]          o_imm,
    output logic                 o_illegal
);

    localparam logic [0:0] S_IDLE        = 1'b0;
    localparam logic [0:0] S_WAIT_HAZARD = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [TAG_WIDTH-1:0] last_tag;
    logic [31:0]          pending_q, pending_d;

    op_e         dec_op;
    logic [31:0] dec_imm;
    logic        uses_rs1, uses_rs2, writes_rd, dec_illegal;
    logic [4:0]  rd_field;
    logic        new_input, hazard, issue;

    cpu_decode_imm u_imm (
        .instruction (i_instruction),
        .op          (dec_op),
        .imm         (dec_imm),
        .uses_rs1    (uses_rs1),
        .uses_rs2    (uses_rs2),
        .writes_rd   (writes_rd),
        .illegal     (dec_illegal)
    );

    assign o_rs1_addr = i_instruction[19:15];
    assign o_rs2_addr = i_instruction[24:20];
    assign rd_field   = i_instruction[11:7];

    // Tags are compared for equality only, so FF -> 00 is just another change.
    assign new_input = (i_tag != last_tag);
    // Bit 0 of the scoreboard is never set, so x0 can never cause a hazard.
    assign hazard    = (uses_rs1 && pending_q[o_rs1_addr]) ||
                       (uses_rs2 && pending_q[o_rs2_addr]);
    assign issue     = new_input && !i_stall && !hazard;
    assign o_busy    = new_input && !issue;

    always_comb begin
        state_d = state_q;
        if (issue)
            state_d = S_IDLE;
        else if (new_input && !i_stall)
            state_d = S_WAIT_HAZARD;
    end

    // Clear first, then set, so an issue targeting the register being written
    // back in the same cycle leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (i_wb_valid && (i_wb_rd != 5'd0))
            pending_d[i_wb_rd] = 1'b0;
        if (issue && writes_rd && (rd_field != 5'd0))
            pending_d[rd_field] = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            last_tag      <= '0;
            pending_q     <= '0;
            o_tag         <= '0;
            o_pc          <= RESET_PC;
            o_instruction <= '0;
            o_op          <= '0;
            o_rd          <= '0;
            o_rs1         <= '0;
            o_rs2         <= '0;
            o_imm         <= '0;
            o_illegal     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (issue) begin
                last_tag      <= i_tag;
                o_tag         <= i_tag;
                o_pc          <= i_pc;
                o_instruction <= i_instruction;
                o_op          <= dec_op;
                o_rd          <= writes_rd ? rd_field : 5'd0;
                o_rs1         <= (o_rs1_addr == 5'd0) ? 32'h0 : i_rs1_data;
                o_rs2         <= (o_rs2_addr == 5'd0) ? 32'h0 : i_rs2_data;
                o_imm         <= dec_imm;
                o_illegal     <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_cpu_decode.sv
module tb_cpu_decode;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        i_clock, i_reset, i_stall, o_busy;
    logic [7:0]  i_tag, o_tag;
    logic [31:0] i_instruction, i_pc;
    logic [4:0]  o_rs1_addr, o_rs2_addr;
    logic [31:0] i_rs1_data, i_rs2_data;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] o_pc, o_instruction;
    logic [3:0]  o_op;
    logic [4:0]  o_rd;
    logic [31:0] o_rs1, o_rs2, o_imm;
    logic        o_illegal;

    logic [31:0] regs [32];
    int n_checks = 0;
    int n_fail   = 0;

    cpu_decode #(.TAG_WIDTH(8), .RESET_PC(RST_PC)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall), .o_busy(o_busy),
        .i_tag(i_tag), .i_instruction(i_instruction), .i_pc(i_pc),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
        .o_tag(o_tag), .o_pc(o_pc), .o_instruction(o_instruction), .o_op(o_op),
        .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_illegal(o_illegal)
    );

    assign i_rs1_data = regs[o_rs1_addr];
    assign i_rs2_data = regs[o_rs2_addr];

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // One-cycle writeback; the modelled regfile takes the new value on that edge.
    task automatic writeback(input logic [4:0] rd, input logic [31:0] val);
        i_wb_valid = 1'b1;
        i_wb_rd    = rd;
        tick();
        if (rd != 5'd0) regs[rd] = val;
        i_wb_valid = 1'b0;
        i_wb_rd    = 5'd0;
    endtask

    initial begin
        vecs[0]  = '{32'h123452B7, OP_LUI,    5'd5, 32'h12345000, 1'b0};
        vecs[1]  = '{32'hFE002E23, OP_STORE,  5'd0, 32'hFFFFFFFC, 1'b0};
        vecs[2]  = '{32'hFE000CE3, OP_BRANCH, 5'd0, 32'hFFFFFFF8, 1'b0};
        vecs[3]  = '{32'h0010006F, OP_JAL,    5'd0, 32'h00000800, 1'b0};
        vecs[4]  = '{32'hFFFFF317, OP_AUIPC,  5'd6, 32'hFFFFF000, 1'b0};
        vecs[5]  = '{32'hFFF00393, OP_IMM,    5'd7, 32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{32'h01000067, OP_JALR,   5'd0, 32'h00000010, 1'b0};
        vecs[7]  = '{32'h00000000, OP_NOP,    5'd0, 32'h00000000, 1'b1};
        vecs[8]  = '{32'hFFFFFFFF, OP_NOP,    5'd0, 32'h00000000, 1'b1};
        vecs[9]  = '{32'h40001013, OP_NOP,    5'd0, 32'h00000000, 1'b1};
        // Reads x31: must not be held by the illegal word with rd field 31.
        vecs[10] = '{32'h01FF8033, OP_ALU,    5'd0, 32'h00000000, 1'b0};

        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        regs[0] = 32'h0;

        i_reset = 1'b1; i_stall = 1'b0; i_tag = 8'd0; i_instruction = 32'h0;
        i_pc = 32'h0; i_wb_valid = 1'b0; i_wb_rd = 5'd0;
        tick(); tick();
        chk("reset o_tag", {24'h0, o_tag}, 32'h0);
        chk("reset o_pc", o_pc, RST_PC);
        chk("reset o_op", {28'h0, o_op}, 32'h0);
        chk("reset o_imm", o_imm, 32'h0);
        i_reset = 1'b0;
        #1;
        chk("reset o_busy", {31'h0, o_busy}, 32'h0);

        // ADDI x1,x0,5
        i_tag = 8'd1; i_instruction = 32'h00500093; i_pc = 32'h100;
        #1 chk("addi busy", {31'h0, o_busy}, 32'h0);
        tick();
        chk("addi o_tag", {24'h0, o_tag}, 32'd1);
        chk("addi o_op", {28'h0, o_op}, {28'h0, OP_IMM});
        chk("addi o_rd", {27'h0, o_rd}, 32'd1);
        chk("addi o_imm", o_imm, 32'd5);
        chk("addi o_rs1", o_rs1, 32'h0);

        // ADD x2,x1,x1 held until x1 is written back
        i_tag = 8'd2; i_instruction = 32'h00108133; i_pc = 32'h104;
        #1 chk("raw busy", {31'h0, o_busy}, 32'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("raw hold o_tag", {24'h0, o_tag}, 32'd1);
            chk("raw hold busy", {31'h0, o_busy}, 32'd1);
        end
        writeback(5'd1, 32'hCAFE0001);
        chk("raw after wb busy", {31'h0, o_busy}, 32'h0);
        tick();
        chk("raw issue o_tag", {24'h0, o_tag}, 32'd2);
        chk("raw issue o_rs1", o_rs1, 32'hCAFE0001);
        chk("raw issue o_rs2", o_rs2, 32'hCAFE0001);
        chk("raw issue o_op", {28'h0, o_op}, {28'h0, OP_ALU});
        chk("raw issue o_rd", {27'h0, o_rd}, 32'd2);
        chk("raw issue o_pc", o_pc, 32'h104);
        writeback(5'd2, 32'h2222_0002);

        // Execute stall for three cycles
        i_stall = 1'b1; i_tag = 8'd3; i_instruction = 32'h00300413; i_pc = 32'h108;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall busy", {31'h0, o_busy}, 32'd1);
            tick();
            chk("stall o_tag", {24'h0, o_tag}, 32'd2);
            chk("stall o_pc", o_pc, 32'h104);
        end
        i_stall = 1'b0;
        #1 chk("unstall busy", {31'h0, o_busy}, 32'h0);
        tick();
        chk("unstall o_tag", {24'h0, o_tag}, 32'd3);
        chk("unstall o_imm", o_imm, 32'd3);
        chk("unstall o_pc", o_pc, 32'h108);
        writeback(5'd8, 32'h8888_0008);

        // Directed decode vectors
        for (int v = 0; v < 11; v++) begin
            i_tag = 8'(4 + v);
            i_instruction = vecs[v].instr;
            i_pc = 32'h200 + 32'(v * 4);
            #1 chk($sformatf("vec%0d busy", v), {31'h0, o_busy}, 32'h0);
            tick();
            chk($sformatf("vec%0d o_tag", v), {24'h0, o_tag}, 32'(4 + v));
            chk($sformatf("vec%0d o_op", v), {28'h0, o_op}, {28'h0, vecs[v].op});
            chk($sformatf("vec%0d o_rd", v), {27'h0, o_rd}, {27'h0, vecs[v].rd});
            chk($sformatf("vec%0d o_imm", v), o_imm, vecs[v].imm);
            chk($sformatf("vec%0d o_illegal", v), {31'h0, o_illegal}, {31'h0, vecs[v].ill});
            chk($sformatf("vec%0d o_instruction", v), o_instruction, vecs[v].instr);
            if (vecs[v].rd != 5'd0) writeback(vecs[v].rd, regs[vecs[v].rd]);
        end

        // Tag wrap, and LW x3 issuing while x3 is being written back
        i_tag = 8'hFF; i_instruction = 32'h00000013; i_pc = 32'h300;
        tick();
        chk("tag ff o_tag", {24'h0, o_tag}, 32'h0000_00FF);
        i_tag = 8'h00; i_instruction = 32'h00002183; i_pc = 32'h304;
        i_wb_valid = 1'b1; i_wb_rd = 5'd3;
        #1 chk("wrap busy", {31'h0, o_busy}, 32'h0);
        tick();
        regs[3] = 32'hBEEF0003;
        i_wb_valid = 1'b0; i_wb_rd = 5'd0;
        chk("wrap o_tag", {24'h0, o_tag}, 32'h0);
        chk("wrap o_op", {28'h0, o_op}, {28'h0, OP_LOAD});
        chk("wrap o_pc", o_pc, 32'h304);
        i_tag = 8'd1; i_instruction = 32'h00018233; i_pc = 32'h308;
        #1 chk("set-wins busy", {31'h0, o_busy}, 32'd1);
        tick();
        chk("set-wins o_tag", {24'h0, o_tag}, 32'h0);
        chk("set-wins hold busy", {31'h0, o_busy}, 32'd1);

        // Reset while waiting on the hazard
        i_reset = 1'b1;
        tick();
        chk("midreset o_tag", {24'h0, o_tag}, 32'h0);
        chk("midreset o_pc", o_pc, RST_PC);
        chk("midreset o_op", {28'h0, o_op}, 32'h0);
        chk("midreset o_rd", {27'h0, o_rd}, 32'h0);
        chk("midreset o_instruction", o_instruction, 32'h0);
        i_reset = 1'b0; i_tag = 8'd5;
        #1 chk("post reset busy", {31'h0, o_busy}, 32'h0);
        tick();
        chk("post reset o_tag", {24'h0, o_tag}, 32'd5);
        chk("post reset o_rs1", o_rs1, 32'hBEEF0003);
        chk("post reset o_rd", {27'h0, o_rd}, 32'd4);
        chk("post reset o_pc", o_pc, 32'h308);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
